// File: rtl/user_pulse_pkg.sv
// user_pulse_pkg: shared FSM/phase/class encodings and counter helpers for user_pulse_decoder.
package user_pulse_pkg;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_e;
   typedef enum logic [1:0] {PH_F1, PH_F2, PH_STOP} phase_e;
   typedef enum logic [1:0] {CLS_F1, CLS_F2, CLS_UNM} cls_e;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
   // one extra bit keeps the distance exact for any pair of 8-bit counts
   function automatic logic near(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b, input logic [CNT_W:0] tol);
      logic [CNT_W:0] d;
      d = a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
      return d <= tol;
   endfunction
endpackage

// File: rtl/user_pulse_meas.sv
// user_pulse_meas: optional input synchronizer (USER_PULSE_DECODER_SYNC_EN), rising-edge detect
// and saturating period/high-time counters that reload to 1 on every rising edge.
module user_pulse_meas
   import user_pulse_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic             rise,
   output logic             level,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high
);
   logic prev;
`ifdef USER_PULSE_DECODER_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[0], pulse_in};
   assign level = sync[1];
`else
   assign level = pulse_in;
`endif
   assign rise = level & ~prev;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev   <= 1'b0;
         period <= '0;
         high   <= '0;
      end else begin
         prev   <= level;
         period <= rise ? CNT_W'(1) : sat_inc(period);
         high   <= rise ? CNT_W'(1) : level ? sat_inc(high) : high;
      end
   end
endmodule

// File: rtl/user_pulse_decoder.sv
// user_pulse_decoder: classifies a F1/F2/STOP pulse burst and counts pulses per phase.
// Define USER_PULSE_DECODER_SYNC_EN to add a 2-flop synchronizer on pulse_in.
module user_pulse_decoder
   import user_pulse_pkg::*;
#(
   parameter int TOL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             start,
   input  logic [CNT_W-1:0] f1_end,
   input  logic [CNT_W-1:0] f1_high,
   input  logic [CNT_W-1:0] f2_end,
   input  logic [CNT_W-1:0] f2_high,
   input  logic             enable_f2,
   input  logic [CNT_W-1:0] idle_timeout,
   output logic             pulse_valid,
   output logic [1:0]       pulse_class,
   output logic [CNT_W-1:0] f1_seen,
   output logic [CNT_W-1:0] f2_seen,
   output logic [CNT_W-1:0] stop_seen,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam logic [CNT_W:0] TOL9 = (CNT_W+1)'(TOL);
   state_e state;
   phase_e phase;
   cls_e cls;
   logic rise, level, last, ev, m1, m2;
   logic [CNT_W-1:0] period, high;
   user_pulse_meas u_meas (
      .clk    (clk),
      .rst_n  (rst_n),
      .pulse_in(pulse_in),
      .rise   (rise),
      .level  (level),
      .period (period),
      .high   (high)
   );
   // the final pulse has no closing edge, so only its high time is judged
   assign last = state == MEASURE && !level && period >= idle_timeout;
   assign ev   = state == MEASURE && (rise || last);
   assign m1   = near(high, f1_high, TOL9) && (last || near(period, f1_end, TOL9));
   assign m2   = enable_f2 && near(high, f2_high, TOL9) && (last || near(period, f2_end, TOL9));
   assign cls  = m1 ? CLS_F1 : m2 ? CLS_F2 : CLS_UNM;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase       <= PH_F1;
         pulse_valid <= 1'b0;
         pulse_class <= '0;
         f1_seen     <= '0;
         f2_seen     <= '0;
         stop_seen   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         pulse_valid <= 1'b0;
         if (start) begin
            state     <= ARMED;
            phase     <= PH_F1;
            f1_seen   <= '0;
            f2_seen   <= '0;
            stop_seen <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
         end else if (state == ARMED && rise) begin
            state <= MEASURE;
         end else if (ev) begin
            pulse_valid <= 1'b1;
            pulse_class <= cls;
            if (last) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            if (cls == CLS_F1) begin
               if (phase == PH_F1) f1_seen <= sat_inc(f1_seen);
               else begin
                  phase     <= PH_STOP;
                  stop_seen <= sat_inc(stop_seen);
               end
            end else if (cls == CLS_F2 && phase != PH_STOP) begin
               phase   <= PH_F2;
               f2_seen <= sat_inc(f2_seen);
            end else err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_user_pulse_decoder.sv
// tb_user_pulse_decoder: randomized + directed bursts; a reference model queues expected strobes.
module tb_user_pulse_decoder;
   localparam int TOL = 1;
   logic clk = 1'b0, rst_n = 1'b0, pulse_in = 1'b0, start = 1'b0, enable_f2 = 1'b0;
   logic [7:0] f1_end = 8'd50, f1_high = 8'd15, f2_end = 8'd25, f2_high = 8'd5, idle_timeout = 8'd100;
   logic pulse_valid, busy, done, err;
   logic [1:0] pulse_class;
   logic [7:0] f1_seen, f2_seen, stop_seen;
   int vectors = 0, miscompares = 0;
   typedef struct {int cls; int f1; int f2; int stop; int err; int done;} exp_t;
   exp_t sb[$];
   int bp[$], bh[$];
   always #5 clk = ~clk;
   user_pulse_decoder #(.TOL(TOL)) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .start(start),
      .f1_end(f1_end), .f1_high(f1_high), .f2_end(f2_end), .f2_high(f2_high),
      .enable_f2(enable_f2), .idle_timeout(idle_timeout),
      .pulse_valid(pulse_valid), .pulse_class(pulse_class),
      .f1_seen(f1_seen), .f2_seen(f2_seen), .stop_seen(stop_seen),
      .busy(busy), .done(done), .err(err)
   );
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (pulse_valid) begin
         if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
         else begin
            e = sb.pop_front();
            chk("class", int'(pulse_class), e.cls);
            chk("f1_seen", int'(f1_seen), e.f1);
            chk("f2_seen", int'(f2_seen), e.f2);
            chk("stop_seen", int'(stop_seen), e.stop);
            chk("err", int'(err), e.err);
            chk("done_at_strobe", int'(done), e.done);
         end
      end
   end
   function automatic bit near(input int a, input int b);
      return (a > b ? a - b : b - a) <= TOL;
   endfunction
   function automatic int classify(input int p, input int h, input bit fin);
      if (near(h, int'(f1_high)) && (fin || near(p, int'(f1_end)))) return 0;
      if (enable_f2 && near(h, int'(f2_high)) && (fin || near(p, int'(f2_end)))) return 1;
      return 2;
   endfunction
   function automatic int inc(input int v);
      return v < 255 ? v + 1 : 255;
   endfunction
   task automatic add(input int p, input int h, input int n);
      for (int i = 0; i < n; i++) begin
         bp.push_back(p);
         bh.push_back(h);
      end
   endtask
   task automatic run_burst(output int rf1, output int rf2, output int rstop, output int rerr);
      int ph = 0, c1 = 0, c2 = 0, cs = 0, e = 0, n, c;
      exp_t x;
      n = bp.size();
      for (int i = 0; i < n; i++) begin
         c = classify(bp[i], bh[i], i == n - 1);
         if (c == 0 && ph == 0) c1 = inc(c1);
         else if (c == 0) begin ph = 2; cs = inc(cs); end
         else if (c == 1 && ph != 2) begin ph = 1; c2 = inc(c2); end
         else e = 1;
         x = '{c, c1, c2, cs, e, (i == n - 1) ? 1 : 0};
         sb.push_back(x);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         pulse_in = 1'b1;
         repeat (bh[i]) cyc();
         pulse_in = 1'b0;
         if (i < n - 1) repeat (bp[i] - bh[i]) cyc();
      end
      for (int k = 0; k < 400 && !done; k++) cyc();
      cyc();
      chk("burst_done", int'(done), 1);
      chk("burst_busy", int'(busy), 0);
      chk("strobes_pending", sb.size(), 0);
      chk("final_f1", int'(f1_seen), c1);
      chk("final_f2", int'(f2_seen), c2);
      chk("final_stop", int'(stop_seen), cs);
      chk("final_err", int'(err), e);
      sb.delete();
      bp.delete();
      bh.delete();
      rf1 = c1; rf2 = c2; rstop = cs; rerr = e;
   endtask
   initial begin
      int a, b, s, e, kind, p, h;
      repeat (3) cyc();
      chk("rst_valid", int'(pulse_valid), 0);
      chk("rst_class", int'(pulse_class), 0);
      chk("rst_f1", int'(f1_seen), 0);
      chk("rst_f2", int'(f2_seen), 0);
      chk("rst_stop", int'(stop_seen), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      rst_n = 1'b1;
      repeat (2) cyc();
      // F1 -> F2 -> STOP
      enable_f2 = 1'b1;
      add(50, 15, 3); add(25, 5, 3); add(50, 15, 3);
      run_burst(a, b, s, e);
      chk("s1_f1", int'(f1_seen), 3); chk("s1_f2", int'(f2_seen), 3);
      chk("s1_stop", int'(stop_seen), 3); chk("s1_err", int'(err), 0);
      // F1 only, F2 disabled
      enable_f2 = 1'b0; f1_end = 8'd40; f1_high = 8'd10;
      add(40, 10, 6);
      run_burst(a, b, s, e);
      chk("s2_f1", int'(f1_seen), 6); chk("s2_stop", int'(stop_seen), 0);
      // F2 first, then F1 goes straight to STOP
      enable_f2 = 1'b1; f1_end = 8'd50; f1_high = 8'd15;
      add(25, 5, 2); add(50, 15, 2);
      run_burst(a, b, s, e);
      chk("s3_f1", int'(f1_seen), 0); chk("s3_f2", int'(f2_seen), 2); chk("s3_stop", int'(stop_seen), 2);
      // unmatched pulse among F1
      f1_end = 8'd40; f1_high = 8'd10;
      add(40, 10, 1); add(40, 30, 1); add(40, 10, 2);
      run_burst(a, b, s, e);
      chk("s4_f1", int'(f1_seen), 3); chk("s4_err", int'(err), 1);
      // tolerance edge
      f1_end = 8'd50; f1_high = 8'd15;
      add(51, 15, 1); add(52, 15, 1); add(50, 15, 1);
      run_burst(a, b, s, e);
      chk("s5_f1", int'(f1_seen), 2); chk("s5_err", int'(err), 1);
      // reset in the middle of a burst
      f1_end = 8'd40; f1_high = 8'd10;
      sb.push_back('{0, 1, 0, 0, 0, 0});
      sb.push_back('{0, 2, 0, 0, 0, 0});
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pulse_in = 1'b1; repeat (10) cyc();
         pulse_in = 1'b0; repeat (30) cyc();
      end
      pulse_in = 1'b1; repeat (5) cyc();
      rst_n = 1'b0; pulse_in = 1'b0;
      repeat (2) cyc();
      chk("s6_rst_f1", int'(f1_seen), 0);
      chk("s6_rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (200) cyc();
      chk("s6_no_strobe", sb.size(), 0);
      chk("s6_idle_done", int'(done), 0);
      add(40, 10, 4);
      run_burst(a, b, s, e);
      chk("s6_f1", int'(f1_seen), 4);
      // random bursts
      for (int r = 0; r < 12; r++) begin
         enable_f2 = 1'($urandom_range(0, 3) != 0);
         f1_end = 8'($urandom_range(30, 70)); f1_high = 8'($urandom_range(3, int'(f1_end) - 3));
         f2_end = 8'($urandom_range(10, 70)); f2_high = 8'($urandom_range(3, int'(f2_end) - 3));
         idle_timeout = 8'($urandom_range(90, 140));
         for (int i = int'($urandom_range(1, 10)); i > 0; i--) begin
            kind = int'($urandom_range(0, 5));
            if (kind <= 1) begin
               p = int'(f1_end) + int'($urandom_range(0, 2)) - 1;
               h = int'(f1_high) + int'($urandom_range(0, 2)) - 1;
            end else if (kind <= 3) begin
               p = int'(f2_end) + int'($urandom_range(0, 2)) - 1;
               h = int'(f2_high) + int'($urandom_range(0, 2)) - 1;
            end else begin
               p = int'($urandom_range(4, 85));
               h = int'($urandom_range(1, p - 1));
            end
            add(p, h, 1);
         end
         run_burst(a, b, s, e);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
